// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encoding, legal width limits and the counter-width helper.
package serial_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 32;

  // One-hot FSM encoding; each output decodes a single state bit.
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SHIFT = 3'b010,
    DONE  = 3'b100
  } state_t;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single combinational full-adder cell used by the serial datapath.
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first, one bit pair per clock.
// A start accepted at edge k yields done at edge k+N; results are held
// until the next done. Optional overflow flag: SERIAL_ADDSUB_OVF_EN.
module serial_addsub
  import serial_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int            CW   = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  ra_q, ra_d;
  logic [N-1:0]  rb_q, rb_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          fa_s, fa_c;
  logic          accept;
  logic          last;

  // A request is honoured whenever no operation is shifting.
  assign accept = start & (state_q != SHIFT);
  assign last   = (state_q == SHIFT) && (cnt_q == LAST);

  serial_fa_cell fa (
    .x (ra_q[0]),
    .y (rb_q[0]),
    .z (carry_q),
    .s (fa_s),
    .c (fa_c)
  );

  // FSM state register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; DONE may chain straight into a new SHIFT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state only.
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  // Operand load on accept, otherwise shift one bit pair per SHIFT cycle.
  // Subtraction loads ~b with carry-in 1, giving a + ~b + 1.
  always_comb begin
    ra_d    = ra_q;
    rb_d    = rb_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (accept) begin
      ra_d    = a;
      rb_d    = sub ? ~b : b;
      carry_d = sub;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      ra_d    = {fa_s, ra_q[N-1:1]};
      rb_d    = {1'b0, rb_q[N-1:1]};
      carry_d = fa_c;
      cnt_d   = cnt_q + CW'(1);
    end
  end

  // Result registers change only on the final shift.
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    if (last) begin
      sum_d  = {fa_s, ra_q[N-1:1]};
      cout_d = fa_c;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      ra_q    <= '0;
      rb_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic cin_msb_q, cin_msb_d;
  logic ovf_q, ovf_d;

  // On the last shift the carry flop holds the carry into bit N-1;
  // overflow is that carry differing from the carry out.
  always_comb begin
    cin_msb_d = last ? carry_q : cin_msb_q;
    ovf_d     = last ? (cin_msb_d ^ fa_c) : ovf_q;
  end

  // Overflow tracking registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      cin_msb_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cin_msb_q <= cin_msb_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: N=4 and N=8 instances checked
// against an arithmetic reference model, directed plus random operations.
module tb_serial_addsub;

`ifdef SERIAL_ADDSUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start4, sub4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;
  logic       start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  int checks = 0;
  int errors = 0;
  int dones8 = 0;
  longint last_t = 0, prev_t = 0;
  int prev4 = 0, prev8 = 0;

  serial_addsub #(.N(4)) u4 (
    .CLK(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  serial_addsub #(.N(8)) u8 (
    .CLK(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  always @(posedge clk) begin
    if (done8) begin
      dones8 <= dones8 + 1;
      prev_t <= last_t;
      last_t <= $time;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic modulo 2^n, signed range test for ovf.
  task automatic model(input int n, input int a, input int b, input bit sub,
                       output int s, output bit c, output bit v);
    longint m, r, sa, sb, rs;
    m  = longint'(1) << n;
    r  = sub ? (longint'(a) - longint'(b)) : (longint'(a) + longint'(b));
    s  = int'(((r % m) + m) % m);
    c  = sub ? (a >= b) : (r >= m);
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    rs = sub ? sa - sb : sa + sb;
    v  = OVF_EN && ((rs < -(m / 2)) || (rs >= m / 2));
  endtask

  task automatic drive(input int sel, input int a, input int b, input bit sub, input bit st);
    if (sel == 4) begin
      a4 = a[3:0]; b4 = b[3:0]; sub4 = sub; start4 = st;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; sub8 = sub; start8 = st;
    end
  endtask

  function automatic logic [31:0] rd_sum(input int sel);
    return (sel == 4) ? {28'b0, sum4} : {24'b0, sum8};
  endfunction
  function automatic logic [31:0] rd_busy(input int sel);
    return (sel == 4) ? {31'b0, busy4} : {31'b0, busy8};
  endfunction
  function automatic logic [31:0] rd_done(input int sel);
    return (sel == 4) ? {31'b0, done4} : {31'b0, done8};
  endfunction
  function automatic logic [31:0] rd_cout(input int sel);
    return (sel == 4) ? {31'b0, cout4} : {31'b0, cout8};
  endfunction
  function automatic logic [31:0] rd_ovf(input int sel);
    return (sel == 4) ? {31'b0, ovf4} : {31'b0, ovf8};
  endfunction

  // Called #1 after an edge; the request is sampled at the next edge.
  task automatic start_op(input int sel, input int a, input int b, input bit sub);
    drive(sel, a, b, sub, 1'b1);
    @(posedge clk); #1;
    drive(sel, a, b, sub, 1'b0);
    chk("start_busy", rd_busy(sel), 32'd1);
    chk("start_done", rd_done(sel), 32'd0);
  endtask

  // Full operation; glitch>0 pulses an ignored start with a=0 after that shift.
  task automatic run_op(input int sel, input int a, input int b, input bit sub, input int glitch);
    int s; bit c, v; int prev;
    model(sel, a, b, sub, s, c, v);
    prev = (sel == 4) ? prev4 : prev8;
    start_op(sel, a, b, sub);
    for (int i = 1; i <= sel; i++) begin
      @(posedge clk); #1;
      if (i < sel) begin
        chk("shift_busy", rd_busy(sel), 32'd1);
        chk("shift_done", rd_done(sel), 32'd0);
        chk("shift_hold", rd_sum(sel), prev);
      end else begin
        chk("fin_done", rd_done(sel), 32'd1);
        chk("fin_busy", rd_busy(sel), 32'd0);
        chk("fin_sum",  rd_sum(sel),  s);
        chk("fin_cout", rd_cout(sel), {31'b0, c});
        chk("fin_ovf",  rd_ovf(sel),  {31'b0, v});
      end
      if (glitch > 0 && i == glitch)     drive(sel, 0, b, sub, 1'b1);
      if (glitch > 0 && i == glitch + 1) drive(sel, 0, b, sub, 1'b0);
    end
    if (sel == 4) prev4 = s; else prev8 = s;
  endtask

  task automatic idle_check(input int sel);
    @(posedge clk); #1;
    chk("idle_done", rd_done(sel), 32'd0);
    chk("idle_busy", rd_busy(sel), 32'd0);
    chk("idle_hold", rd_sum(sel), (sel == 4) ? prev4 : prev8);
  endtask

  initial begin
    int d;
    rst = 1'b1;
    drive(4, 0, 0, 1'b0, 1'b0);
    drive(8, 0, 0, 1'b0, 1'b0);
    #1;
    chk("rst_busy8", {31'b0, busy8}, 32'd0);
    chk("rst_done8", {31'b0, done8}, 32'd0);
    chk("rst_sum8",  {24'b0, sum8},  32'd0);
    chk("rst_cout8", {31'b0, cout8}, 32'd0);
    chk("rst_ovf8",  {31'b0, ovf8},  32'd0);
    chk("rst_sum4",  {28'b0, sum4},  32'd0);
    chk("rst_busy4", {31'b0, busy4}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_check(8);

    // Directed N=4 cases.
    run_op(4, 4'b1001, 4'b1010, 1'b0, 0); idle_check(4);
    run_op(4, 4'b1001, 4'b1010, 1'b1, 0); idle_check(4);
    run_op(4, 4'b0111, 4'b0001, 1'b0, 0); idle_check(4);

    // Start while busy is ignored.
    d = dones8;
    run_op(8, 8'hFF, 8'h01, 1'b0, 3);
    idle_check(8);
    chk("one_done", dones8 - d, 32'd1);

    // Reset in the middle of an operation.
    start_op(8, 8'h55, 8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_busy", {31'b0, busy8}, 32'd0);
    chk("mid_done", {31'b0, done8}, 32'd0);
    chk("mid_sum",  {24'b0, sum8},  32'd0);
    chk("mid_cout", {31'b0, cout8}, 32'd0);
    chk("mid_ovf",  {31'b0, ovf8},  32'd0);
    prev8 = 0; prev4 = 0;
    d = dones8;
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("no_done_after_rst", dones8, d);
    run_op(8, 8'h10, 8'h22, 1'b0, 0); idle_check(8);

    // Back-to-back operations chained in the DONE cycle.
    run_op(8, 3, 4, 1'b0, 0);
    run_op(8, 10, 5, 1'b1, 0);
    idle_check(8);
    chk("b2b_spacing", 32'(last_t - prev_t), 32'd90);

    // Random operations on both widths, sometimes chained.
    for (int k = 0; k < 16; k++) begin
      run_op(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom), 0);
      if ($urandom_range(0, 1) == 1) idle_check(8);
    end
    idle_check(8);
    for (int k = 0; k < 10; k++) begin
      run_op(4, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom), 0);
      if ($urandom_range(0, 1) == 1) idle_check(4);
    end
    idle_check(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
